// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: buffers source bits and emits preamble / payload / tail
// frames one bit per bit_en tick, driving encoder and interleaver markers.
module tx_frame_sched #(
   parameter int unsigned PREAMBLE_LEN = 16,
   parameter logic [31:0] PREAMBLE     = 32'h0000A5F0,
   parameter int unsigned PAYLOAD_LEN  = 64,
   parameter int unsigned TAIL_LEN     = 6,
   parameter int unsigned FIFO_DEPTH   = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_en,
   input  logic src_bit,
   input  logic src_valid,
   output logic src_full,
   output logic overflow,
   output logic out_bit,
   output logic out_valid,
   output logic frame_start,
   output logic payload_start,
   output logic enc_bypass,
   output logic enc_flush,
   output logic busy
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned MAX_LEN = (PREAMBLE_LEN > PAYLOAD_LEN)
                                     ? ((PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN)
                                     : ((PAYLOAD_LEN > TAIL_LEN) ? PAYLOAD_LEN : TAIL_LEN);
   localparam int unsigned IDX_W   = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {IDLE, PRE, PAY, TAIL} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [FIFO_DEPTH-1:0] mem;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full, push, pop, head;
   logic [4:0]         pre_sel;
   logic               emit, emit_bit, emit_fs, emit_ps, emit_byp, emit_fl;

   // ---------------- source FIFO ----------------
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   // A pop in the same cycle frees the head slot, so a write while full is still accepted.
   assign push     = src_valid && (!full || pop);
   assign head     = mem[rd_ptr];
   assign src_full = full;

   // NOTE: the storage array has no reset; stale contents are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= src_bit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (src_valid && full && !pop) overflow <= 1'b1;
      end
   end

   // ---------------- frame FSM ----------------
   assign pre_sel = 5'(PREAMBLE_LEN - 1 - 32'(idx_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every output of this block gets a default first so no latch can be inferred;
   // blocking assignments are correct here, while the clocked blocks use non-blocking only.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pop      = 1'b0;
      emit     = 1'b0;
      emit_bit = 1'b0;
      emit_fs  = 1'b0;
      emit_ps  = 1'b0;
      emit_byp = 1'b0;
      emit_fl  = 1'b0;
      if (bit_en) begin
         case (state_q)
            IDLE: begin
               // Start only with a whole payload buffered, so PAY can never underflow.
               if (count >= CNT_W'(PAYLOAD_LEN)) begin
                  emit     = 1'b1;
                  emit_bit = PREAMBLE[PREAMBLE_LEN-1];
                  emit_fs  = 1'b1;
                  emit_byp = 1'b1;
                  idx_d    = IDX_W'(1);
                  state_d  = PRE;
               end
            end
            PRE: begin
               emit = 1'b1;
               if (idx_q == IDX_W'(PREAMBLE_LEN)) begin
                  pop      = 1'b1;
                  emit_bit = head;
                  emit_ps  = 1'b1;
                  idx_d    = IDX_W'(1);
                  state_d  = PAY;
               end else begin
                  emit_bit = PREAMBLE[pre_sel];
                  emit_byp = 1'b1;
                  idx_d    = idx_q + IDX_W'(1);
               end
            end
            PAY: begin
               if (idx_q == IDX_W'(PAYLOAD_LEN)) begin
                  if (TAIL_LEN > 0) begin
                     emit    = 1'b1;
                     emit_fl = 1'b1;
                     idx_d   = IDX_W'(1);
                     state_d = TAIL;
                  end else begin
                     idx_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  pop      = 1'b1;
                  emit     = 1'b1;
                  emit_bit = head;
                  idx_d    = idx_q + IDX_W'(1);
               end
            end
            TAIL: begin
               if (idx_q == IDX_W'(TAIL_LEN)) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  emit    = 1'b1;
                  emit_fl = 1'b1;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
            default: begin
               idx_d   = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_bit       <= 1'b0;
         frame_start   <= 1'b0;
         payload_start <= 1'b0;
         enc_bypass    <= 1'b0;
         enc_flush     <= 1'b0;
      end else begin
         out_valid     <= emit;
         out_bit       <= emit_bit;
         frame_start   <= emit_fs;
         payload_start <= emit_ps;
         enc_bypass    <= emit_byp;
         enc_flush     <= emit_fl;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched: expected beats are queued as stimulus is driven
// and compared as the DUT emits them.
module tb_tx_frame_sched;

   localparam int          PRE_LEN = 4;
   localparam logic [31:0] PRE     = 32'h0000000A;
   localparam int          PAY_LEN = 8;
   localparam int          TL_LEN  = 2;
   localparam int          DEPTH   = 8;
   localparam int          FRAME   = PRE_LEN + PAY_LEN + TL_LEN;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bit_en = 1'b0;
   logic src_bit = 1'b0;
   logic src_valid = 1'b0;
   logic src_full, overflow, out_bit, out_valid;
   logic frame_start, payload_start, enc_bypass, enc_flush, busy;

   tx_frame_sched #(
      .PREAMBLE_LEN (PRE_LEN),
      .PREAMBLE     (PRE),
      .PAYLOAD_LEN  (PAY_LEN),
      .TAIL_LEN     (TL_LEN),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bit_en        (bit_en),
      .src_bit       (src_bit),
      .src_valid     (src_valid),
      .src_full      (src_full),
      .overflow      (overflow),
      .out_bit       (out_bit),
      .out_valid     (out_valid),
      .frame_start   (frame_start),
      .payload_start (payload_start),
      .enc_bypass    (enc_bypass),
      .enc_flush     (enc_flush),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // {bit, frame_start, payload_start, enc_bypass, enc_flush}
   typedef struct packed {
      logic b;
      logic fs;
      logic ps;
      logic byp;
      logic fl;
   } beat_t;

   beat_t sb[$];
   int    fs_ticks[$];
   int    tick_no = 0;
   int    checks  = 0;
   int    errors  = 0;
   bit    tick_on = 1'b0;
   int    phase   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) if (bit_en) tick_no <= tick_no + 1;

   always @(negedge clk) begin
      beat_t obs, e;
      obs = {out_bit, frame_start, payload_start, enc_bypass, enc_flush};
      if (out_valid === 1'b1) begin
         if (frame_start === 1'b1) fs_ticks.push_back(tick_no);
         if (sb.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
         else begin
            e = sb.pop_front();
            check("beat", obs, e);
         end
      end else begin
         check("idle_flags", {frame_start, payload_start, enc_bypass, enc_flush}, 4'b0000);
      end
   end

   // One clock of stimulus; bit_en fires every 4th cycle while tick_on is set.
   task automatic cyc(input logic v, input logic b);
      src_valid = v;
      src_bit   = b;
      bit_en    = tick_on && (phase == 3);
      phase     = (phase + 1) % 4;
      @(negedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] p, input int n);
      beat_t f[$];
      beat_t x;
      for (int i = 0; i < PRE_LEN; i++) begin
         x = {PRE[PRE_LEN-1-i], (i == 0), 1'b0, 1'b1, 1'b0};
         f.push_back(x);
      end
      for (int i = 0; i < PAY_LEN; i++) begin
         x = {p[7-i], 1'b0, (i == 0), 1'b0, 1'b0};
         f.push_back(x);
      end
      for (int i = 0; i < TL_LEN; i++) begin
         x = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         f.push_back(x);
      end
      for (int i = 0; i < n; i++) sb.push_back(f[i]);
   endtask

   task automatic push_byte(input logic [7:0] p);
      for (int i = 0; i < 8; i++) cyc(1'b1, p[7-i]);
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
         cyc(1'b0, 1'b0);
         n++;
      end
      check(tag, {sb.size() == 0, busy}, 2'b10);
   endtask

   initial begin
      logic [7:0]  p;
      logic [15:0] d;
      logic        x1, x2;
      int          n;

      // Reset held with inputs toggling
      rst = 1'b1;
      tick_on = 1'b1;
      for (int i = 0; i < 3; i++) cyc(i % 2 == 0, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_src_full", src_full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_out_bit", out_bit, 1'b0);
      rst = 1'b0;
      repeat (8) cyc(1'b0, 1'b0);
      check("rst_no_frame", busy, 1'b0);

      // Single frame
      p = 8'b11001010;
      push_frame(p, FRAME);
      push_byte(p);
      drain("single_drain", 200);

      // Back-to-back frames, FIFO refilled while the first payload drains
      d = 16'($urandom);
      push_frame(d[15:8], FRAME);
      push_frame(d[7:0], FRAME);
      for (int i = 0; i < 16; i++) begin
         n = 0;
         while (src_full === 1'b1 && n < 100) begin
            cyc(1'b0, 1'b0);
            n++;
         end
         check("b2b_space_wait", src_full, 1'b0);
         cyc(1'b1, d[15-i]);
      end
      drain("b2b_drain", 400);
      check("b2b_frame_period",
            fs_ticks[fs_ticks.size()-1] - fs_ticks[fs_ticks.size()-2], FRAME + 1);

      // Push and pop in the same cycle while full
      tick_on = 1'b0;
      p = 8'($urandom);
      push_frame(p, FRAME);
      push_byte(p);
      check("pp_full_after_8", src_full, 1'b1);
      check("pp_ovf_after_8", overflow, 1'b0);
      tick_on = 1'b1;
      n = 0;
      while (sb.size() > FRAME - PRE_LEN - 1 && n < 100) begin
         cyc(1'b0, 1'b0);
         n++;
      end
      check("pp_reached_payload", sb.size(), FRAME - PRE_LEN - 1);
      x1 = 1'($urandom);
      x2 = 1'($urandom);
      cyc(1'b1, x1);
      check("pp_refilled", src_full, 1'b1);
      while (phase != 3) cyc(1'b0, 1'b0);
      cyc(1'b1, x2);
      check("pp_full_kept", src_full, 1'b1);
      check("pp_no_overflow", overflow, 1'b0);
      cyc(1'b0, 1'b0);
      check("pp_full_next", src_full, 1'b1);
      drain("pp_drain", 300);
      rst = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      check("pp_rst_full", src_full, 1'b0);

      // Overflow with no bit_en
      tick_on = 1'b0;
      p = 8'($urandom);
      push_byte(p);
      check("ovf_full_after_8", src_full, 1'b1);
      check("ovf_clear_after_8", overflow, 1'b0);
      cyc(1'b1, ~p[7]);
      check("ovf_set_after_9", overflow, 1'b1);
      check("ovf_full_after_9", src_full, 1'b1);
      push_frame(p, FRAME);
      tick_on = 1'b1;
      drain("ovf_drain", 200);
      check("ovf_sticky", overflow, 1'b1);
      check("ovf_fifo_empty", src_full, 1'b0);
      repeat (12) cyc(1'b0, 1'b0);
      check("ovf_no_extra_frame", busy, 1'b0);

      // Reset during payload after three payload bits
      p = 8'($urandom);
      push_frame(p, PRE_LEN + 3);
      push_byte(p);
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         cyc(1'b0, 1'b0);
         n++;
      end
      check("abort_reached_pay", busy, 1'b1);
      rst = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_overflow", overflow, 1'b0);
      repeat (24) cyc(1'b0, 1'b0);
      check("abort_idle", busy, 1'b0);
      p = 8'($urandom);
      push_frame(p, FRAME);
      push_byte(p);
      drain("fresh_drain", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_frame_sched.md
# tx_frame_sched

Transmit-side frame scheduler between the UART/sampling source and the encoder. It buffers source bits in an internal FIFO and releases them one bit per slow-clock tick as fixed frames: sync preamble, then payload, then zero tail bits. It drives the encoder bypass/flush controls and the interleaver frame markers, so the downstream chain runs one frame at a time without source-side pacing.

## Interface
- PREAMBLE_LEN, 16, preamble length in bits (1..32)
- PREAMBLE, 32'h0000A5F0, preamble pattern; low PREAMBLE_LEN bits are sent MSB-first
- PAYLOAD_LEN, 64, payload bits per frame (1..FIFO_DEPTH)
- TAIL_LEN, 6, zero bits appended to terminate the encoder (0..15)
- FIFO_DEPTH, 128, source buffer depth in bits (power of 2, ≥ PAYLOAD_LEN)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bit_en  in  1  slow-clock enable from clock generator; one output bit per asserted cycle
- src_bit  in  1  source data bit
- src_valid  in  1  one-cycle write strobe for src_bit
- src_full  out  1  FIFO full (count == FIFO_DEPTH)
- overflow  out  1  sticky; set when src_valid arrives while full
- out_bit  out  1  bit to encoder
- out_valid  out  1  one-cycle strobe qualifying out_bit
- frame_start  out  1  pulses with the first preamble bit
- payload_start  out  1  pulses with the first payload bit; interleaver block boundary
- enc_bypass  out  1  high with preamble bits; encoder passes them uncoded
- enc_flush  out  1  high with tail bits
- busy  out  1  high while state ≠ IDLE

## Operation
- States are IDLE, PRE, PAY, and TAIL. A bit index `idx` counts bits emitted in the current state.
- State changes and emissions happen only on cycles with bit_en=1. All other cycles hold state.
- IDLE: on bit_en with count ≥ PAYLOAD_LEN, emit preamble bit PREAMBLE_LEN-1, set frame_start, set idx=1, go to PRE. Otherwise emit nothing.
- PRE: on bit_en, emit PREAMBLE[PREAMBLE_LEN-1-idx] with enc_bypass=1. After the last preamble bit, the next bit_en emits the first payload (FIFO pop) with payload_start and enters PAY.
- PAY: on bit_en, pop the FIFO head and emit it. After PAYLOAD_LEN pops:
  - TAIL_LEN>0: the next bit_en emits 0 with enc_flush=1 and enters TAIL.
  - TAIL_LEN=0: go to IDLE.
- TAIL: emit 0 with enc_flush=1 until TAIL_LEN zeros have been sent, then go to IDLE.
- IDLE is re-evaluated on the next bit_en, so back-to-back frames are separated by exactly one idle tick.
- Payload cannot underflow, because a frame starts only when a full payload is buffered.
- FIFO:
  - Write on src_valid when not full.
  - Write while full: the bit is dropped and overflow is set. overflow clears only on rst.
  - Push and pop in the same cycle: count unchanged. This is legal even when full, because the pop frees the slot first.
  - Pointers wrap modulo FIFO_DEPTH.
- Count width is clog2(FIFO_DEPTH)+1. idx width covers max(PREAMBLE_LEN, PAYLOAD_LEN, TAIL_LEN).

## Timing
- All outputs are registered. An emission decided on a bit_en cycle appears on out_bit/out_valid and its marker flags in the following cycle, for exactly one cycle.
- enc_bypass, enc_flush, frame_start and payload_start are valid only while out_valid=1 and are 0 otherwise.
- busy follows the registered state, one cycle after the transition.
- src_full and overflow update the cycle after the causing write. The FIFO read is first-word-fall-through internally.
- Frame length is PREAMBLE_LEN+PAYLOAD_LEN+TAIL_LEN bit_en ticks. Frame period is that length +1 tick when data is continuously available.
- Reset values: state IDLE, count 0, pointers 0, idx 0. All outputs 0.
- Reset mid-frame: the frame is aborted, FIFO contents are discarded, and no further out_valid appears until a new full payload is buffered.

## Test plan
- Reset: hold rst 3 cycles with bit_en and src_valid toggling -> all outputs 0, busy 0, no out_valid.
- Single frame (PREAMBLE_LEN=4, PREAMBLE=4'hA, PAYLOAD_LEN=8, TAIL_LEN=2), push 8'b11001010, bit_en every 4th cycle -> out sequence 1010 (bypass) 11001010 (payload_start on first) 00 (flush). frame_start on first bit. busy drops after the last tail bit.
- Back-to-back: push 16 bits before the first frame ends -> second frame_start exactly one bit_en tick after the last tail bit, payload identical to the second 8 pushed bits.
- Overflow (FIFO_DEPTH=8): push 9 bits with no bit_en -> src_full=1 after the 8th, overflow=1 after the 9th. The 9th bit is absent from the payload.
- Push and pop same cycle while full -> count stays 8, src_full stays 1, overflow stays 0.
- Reset during PAY (after 3 payload bits) -> out_valid stops. Push 8 new bits -> a complete fresh frame containing only the new bits.
